// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the 2-input gate unit: sweeps all (a,b) combinations, compares the
// 8-bit gate result to the golden truth table and accumulates error statistics.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [7:0]       gate_res_i,
    output logic [1:0]       ab_drv_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [7:0]       fail_vec_o,
    output logic [1:0]       fail_idx_o,
    output logic             fail_vld_o
);

    typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

    localparam int unsigned SettleM1   = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;
    localparam logic [3:0]  SettleLoad = 4'(SettleM1);
    localparam logic [7:0]  LastLoop   = 8'(LOOPS - 1);
    // With no settle time each combination lives only in the sample state.
    localparam state_e      FirstSt    = (SETTLE_CYC == 0) ? StSample : StApply;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       loop_q, loop_d;
    logic [3:0]       settle_q, settle_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       fail_vec_q, fail_vec_d;
    logic [1:0]       fail_idx_q, fail_idx_d;
    logic             fail_vld_q, fail_vld_d;
    logic [7:0]       golden;
    logic [7:0]       diff;

    always_comb begin
        unique case (idx_q)
            2'd0:    golden = 8'hF8;
            2'd1:    golden = 8'h8E;
            2'd2:    golden = 8'h4E;
            default: golden = 8'h23;
        endcase
    end

    assign diff = gate_res_i ^ golden;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        loop_d     = loop_q;
        settle_d   = settle_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        fail_idx_d = fail_idx_q;
        fail_vld_d = fail_vld_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    err_cnt_d  = '0;
                    fail_vec_d = '0;
                    fail_idx_d = '0;
                    fail_vld_d = 1'b0;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    loop_d     = '0;
                    settle_d   = SettleLoad;
                    state_d    = FirstSt;
                end
            end
            StApply: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else if (settle_q == '0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StSample: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    if (diff != '0) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        fail_vec_d = fail_vec_q | diff;
                        if (!fail_vld_q) begin
                            fail_idx_d = idx_q;
                            fail_vld_d = 1'b1;
                        end
                    end
                    settle_d = SettleLoad;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = FirstSt;
                    end else if (loop_q < LastLoop) begin
                        idx_d   = '0;
                        loop_d  = loop_q + 8'd1;
                        state_d = FirstSt;
                    end else begin
                        pass_d  = (err_cnt_d == '0);
                        state_d = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies decoded from the next state.
        busy_d = (state_d == StApply) || (state_d == StSample);
        done_d = (state_d == StDone);
        ab_d   = busy_d ? idx_d : 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            loop_q     <= '0;
            settle_q   <= '0;
            ab_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
            fail_idx_q <= '0;
            fail_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            loop_q     <= loop_d;
            settle_q   <= settle_d;
            ab_q       <= ab_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            fail_idx_q <= fail_idx_d;
            fail_vld_q <= fail_vld_d;
        end
    end

    assign ab_drv_o   = ab_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign fail_vec_o = fail_vec_q;
    assign fail_idx_o = fail_idx_q;
    assign fail_vld_o = fail_vld_q;

endmodule
